// File: rtl/led_scanner_pkg.sv
// Shared state, mode and direction encodings for the LED scanner.
package led_scanner_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_STEP  = 2'b01,
        S_WAIT  = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    localparam logic [1:0] M_BOUNCE = 2'b00;
    localparam logic [1:0] M_ROTL   = 2'b01;
    localparam logic [1:0] M_ROTR   = 2'b10;
    localparam logic [1:0] M_HOLD   = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_scanner_if.sv
// Control, LED and debug signals of the LED scanner.
interface led_scanner_if #(
    parameter int NUM_LEDS = 4,
    parameter int DWELL_W  = 8
);
    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic                en;
    logic [1:0]          mode;
    logic [DWELL_W-1:0]  dwell;
    logic [NUM_LEDS-1:0] leds;
    logic                blink;
    logic                step_pulse;
    logic [1:0]          dbg_state;
    logic [DWELL_W-1:0]  dbg_ctimer;
    logic [PW-1:0]       dbg_pos;

    modport master (
        output en, mode, dwell,
        input  leds, blink, step_pulse, dbg_state, dbg_ctimer, dbg_pos
    );

    modport slave (
        input  en, mode, dwell,
        output leds, blink, step_pulse, dbg_state, dbg_ctimer, dbg_pos
    );

endinterface

// File: rtl/led_scanner_tick_prescaler.sv
// Free-running prescaler that advances only while run is high; tick marks the wrap cycle.
module tick_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic clk,
    input  logic rst_l,
    input  logic run,
    output logic tick
);

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            cnt <= '0;
        else if (run)
            cnt <= cnt + 1'b1;
    end

    assign tick = run & (&cnt);

endmodule

// File: rtl/led_scanner.sv
// Single-LED scanner: bounce / rotate / hold with run-time dwell in prescaler ticks.
//   state   | meaning
//   S_IDLE  | after reset, waiting for en
//   S_STEP  | one cycle: move pos, toggle blink, load ctimer from dwell
//   S_WAIT  | dwell countdown on prescaler ticks
//   S_PAUSE | en low: prescaler, ctimer and leds frozen
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int NUM_LEDS   = 4,
    parameter int PRESCALE_W = 16,
    parameter int DWELL_W    = 8
) (
    input  logic          clk,
    input  logic          rst_l,
    led_scanner_if.slave  bus
);

    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_LEDS - 1);

    state_t              state, state_n;
    logic [PW-1:0]       pos, pos_n, pos_inc, pos_dec;
    logic                dir, dir_n;
    logic [DWELL_W-1:0]  ctimer;
    logic [NUM_LEDS-1:0] leds_q;
    logic                blink_q, pulse_q;
    logic                tick;

    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk   (clk),
        .rst_l (rst_l),
        .run   ((state == S_WAIT) || (state == S_STEP)),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.en) state_n = S_STEP;
            S_STEP:  state_n = bus.en ? S_WAIT : S_PAUSE;
            S_WAIT:  begin
                if (ctimer == '0)
                    state_n = S_STEP;
                else if (!bus.en)
                    state_n = S_PAUSE;
            end
            S_PAUSE: if (bus.en) state_n = S_WAIT;
            default: state_n = S_IDLE;
        endcase
    end

    // Bounce turns around on the step that lands on an end LED.
    always_comb begin
        pos_inc = pos + PW'(1);
        pos_dec = pos - PW'(1);
        pos_n   = pos;
        dir_n   = dir;
        case (bus.mode)
            M_BOUNCE: begin
                if (dir == DIR_UP) begin
                    if (pos == LAST) begin
                        pos_n = pos_dec;
                        dir_n = DIR_DOWN;
                    end else begin
                        pos_n = pos_inc;
                        if (pos_inc == LAST) dir_n = DIR_DOWN;
                    end
                end else begin
                    if (pos == '0) begin
                        pos_n = pos_inc;
                        dir_n = DIR_UP;
                    end else begin
                        pos_n = pos_dec;
                        if (pos_dec == '0) dir_n = DIR_UP;
                    end
                end
            end
            M_ROTL:  pos_n = (pos == LAST) ? '0 : pos_inc;
            M_ROTR:  pos_n = (pos == '0) ? LAST : pos_dec;
            default: pos_n = pos;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pos     <= '0;
            dir     <= DIR_UP;
            leds_q  <= NUM_LEDS'(1);
            blink_q <= 1'b0;
            pulse_q <= 1'b0;
            ctimer  <= '0;
        end else begin
            pulse_q <= (state == S_STEP);
            if (state == S_STEP) begin
                pos     <= pos_n;
                dir     <= dir_n;
                leds_q  <= NUM_LEDS'(1) << pos_n;
                blink_q <= ~blink_q;
                ctimer  <= bus.dwell;
            end else if ((state == S_WAIT) && tick && (ctimer != '0)) begin
                ctimer  <= ctimer - 1'b1;
            end
        end
    end

    assign bus.leds       = leds_q;
    assign bus.blink      = blink_q;
    assign bus.step_pulse = pulse_q;
    assign bus.dbg_state  = state;
    assign bus.dbg_ctimer = ctimer;
    assign bus.dbg_pos    = pos;

endmodule

// File: tb/tb_led_scanner.sv
// Randomized bench for led_scanner against a cycle-level reference model.
module tb_led_scanner;

    localparam int N      = 4;
    localparam int PSW    = 2;
    localparam int DW     = 8;
    localparam int PS_MOD = 1 << PSW;

    logic clk;
    logic rst_l;

    led_scanner_if #(.NUM_LEDS(N), .DWELL_W(DW)) bus ();

    led_scanner #(.NUM_LEDS(N), .PRESCALE_W(PSW), .DWELL_W(DW)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: phase uses the published debug state codes
    int m_phase, m_pos, m_dir, m_blink, m_ct, m_act, m_pulse;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_dir = 0; m_blink = 0;
        m_ct = 0; m_act = 0; m_pulse = 0;
    endtask

    // Bounce is a triangle wave over 2N-2 phases; dir picks the side of the wave.
    task automatic model_move(input int mode);
        int k;
        case (mode)
            0: begin
                k = (m_dir == 0) ? m_pos : (2*N - 2 - m_pos);
                k = (k + 1) % (2*N - 2);
                m_pos = (k < N) ? k : (2*N - 2 - k);
                m_dir = (k >= N - 1) ? 1 : 0;
            end
            1: m_pos = (m_pos + 1) % N;
            2: m_pos = (m_pos + N - 1) % N;
            default: ;
        endcase
    endtask

    task automatic model_update();
        int  nxt_pulse;
        bit  t;
        if (!rst_l) begin
            model_reset();
            return;
        end
        nxt_pulse = (m_phase == 1);
        case (m_phase)
            0: if (bus.en) m_phase = 1;
            1: begin
                model_move(int'(bus.mode));
                m_blink ^= 1;
                m_ct = int'(bus.dwell);
                m_act = (m_act + 1) % PS_MOD;
                m_phase = bus.en ? 2 : 3;
            end
            2: begin
                t = (m_act == PS_MOD - 1);
                m_act = (m_act + 1) % PS_MOD;
                if (m_ct == 0)
                    m_phase = 1;
                else begin
                    if (t) m_ct--;
                    if (!bus.en) m_phase = 3;
                end
            end
            default: if (bus.en) m_phase = 2;
        endcase
        m_pulse = nxt_pulse;
    endtask

    task automatic compare();
        chk("leds",       32'(bus.leds),       32'(1 << m_pos));
        chk("onehot",     32'($onehot(bus.leds)), 32'd1);
        chk("blink",      32'(bus.blink),      32'(m_blink));
        chk("step_pulse", 32'(bus.step_pulse), 32'(m_pulse));
        chk("state",      32'(bus.dbg_state),  32'(m_phase));
        chk("ctimer",     32'(bus.dbg_ctimer), 32'(m_ct));
        chk("pos",        32'(bus.dbg_pos),    32'(m_pos));
    endtask

    task automatic cycle();
        model_update();
        @(negedge clk);
        compare();
    endtask

    initial begin
        bit found;
        rst_l     = 1'b0;
        bus.en    = 1'b1;
        bus.mode  = 2'b00;
        bus.dwell = 8'd2;
        model_reset();
        repeat (3) cycle();

        rst_l = 1'b1;
        repeat (80) cycle();

        bus.dwell = 8'd0;
        repeat (20) cycle();

        bus.dwell = 8'd1;
        bus.mode  = 2'b01;
        repeat (40) cycle();
        bus.mode  = 2'b10;
        repeat (40) cycle();

        // rotate-left up to the last LED, then switch to bounce
        bus.mode = 2'b01;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            if (m_pos == N - 1 && m_phase != 1) found = 1;
        end
        chk("mode_sw_setup", 32'(found), 32'd1);
        bus.mode = 2'b00;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (bus.step_pulse) found = 1;
        end
        chk("mode_sw_seen", 32'(found), 32'd1);
        chk("mode_sw_pos",  32'(bus.dbg_pos), 32'd2);
        chk("mode_sw_leds", 32'(bus.leds),    32'b0100);

        // pause with ctimer=2 on a non-tick WAIT cycle
        bus.dwell = 8'd2;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            if (m_phase == 2 && m_ct == 2 && m_act != PS_MOD - 1) found = 1;
        end
        chk("pause_setup", 32'(found), 32'd1);
        bus.en = 1'b0;
        repeat (50) cycle();
        chk("pause_state", 32'(bus.dbg_state),  32'd3);
        chk("pause_ct",    32'(bus.dbg_ctimer), 32'd2);
        bus.en = 1'b1;
        cycle();
        chk("resume_state", 32'(bus.dbg_state),  32'd2);
        chk("resume_ct",    32'(bus.dbg_ctimer), 32'd2);
        repeat (20) cycle();

        for (int i = 0; i < 1500; i++) begin
            bus.en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 29) == 0) begin
                bus.mode  = 2'($urandom_range(0, 3));
                bus.dwell = 8'($urandom_range(0, 3));
            end
            cycle();
        end

        // hold mode, then asynchronous reset between clock edges
        bus.en    = 1'b1;
        bus.mode  = 2'b11;
        bus.dwell = 8'd3;
        repeat (30) cycle();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (m_phase == 2 && m_ct != 0) found = 1;
        end
        chk("arst_setup", 32'(found), 32'd1);
        rst_l = 1'b0;
        #1;
        chk("arst_leds",  32'(bus.leds),       32'd1);
        chk("arst_blink", 32'(bus.blink),      32'd0);
        chk("arst_pulse", 32'(bus.step_pulse), 32'd0);
        chk("arst_state", 32'(bus.dbg_state),  32'd0);
        chk("arst_ct",    32'(bus.dbg_ctimer), 32'd0);
        chk("arst_pos",   32'(bus.dbg_pos),    32'd0);
        repeat (2) cycle();
        rst_l = 1'b1;
        repeat (40) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
